// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
// Named s/m encodings cover the common ALU operations.
package alu_seq_pkg;

  localparam int NIBBLES = 4;
  localparam int WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic       M_ADD = 1'b0;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic       M_SUB = 1'b0;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic       M_XOR = 1'b1;
  localparam logic [3:0] S_AND = 4'b1011;
  localparam logic       M_AND = 1'b1;

endpackage

// File: rtl/alu4_slice.sv
// Combinational SN74181 4-bit ALU slice, active-high data convention,
// active-low carry in/out, open-collector style A=B output modelled as &f.
module alu4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn_n,
  output logic [3:0] f,
  output logic       cn4_n,
  output logic       aeqb
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] h;
  logic [4:0] c;

  // c is the active-high internal carry; logic mode forces the carry term high,
  // which inverts the half-sum exactly as the real part does.
  always_comb begin
    g    = '0;
    p    = '0;
    h    = '0;
    f    = '0;
    c    = '0;
    c[0] = ~cn_n;
    for (int i = 0; i < 4; i++) begin
      g[i]     = (a[i] & b[i] & s[3]) | (a[i] & ~b[i] & s[2]);
      p[i]     = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
      h[i]     = p[i] & ~g[i];
      c[i+1]   = g[i] | (p[i] & c[i]);
      f[i]     = h[i] ^ (m | c[i]);
    end
  end

  assign cn4_n = ~c[4];
  assign aeqb  = &f;

endmodule

// File: rtl/alu_nibble_sequencer.sv
// 16-bit 74181-function unit built by stepping one 4-bit slice over four nibbles.
// Optional aeqb output is enabled by defining ALU_SEQ_AEQB_EN.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  s,
  input  logic        m,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        cout,
  output logic        zero,
  output logic        busy
`ifdef ALU_SEQ_AEQB_EN
  ,
  output logic        aeqb
`endif
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  s_q, s_d;
  logic        m_q, m_d;
  logic        carry_q, carry_d;
  logic [15:0] result_q, result_d;
  logic        cout_q, cout_d;

  logic [3:0]  slice_f;
  logic        slice_cn4_n;
  logic        slice_aeqb;

  alu4_slice u_slice (
    .a     (a_q[4*cnt_q +: 4]),
    .b     (b_q[4*cnt_q +: 4]),
    .s     (s_q),
    .m     (m_q),
    .cn_n  (~carry_q),
    .f     (slice_f),
    .cn4_n (slice_cn4_n),
    .aeqb  (slice_aeqb)
  );

`ifdef ALU_SEQ_AEQB_EN
  logic aeqb_q, aeqb_d;
`else
  logic slice_aeqb_unused;
  assign slice_aeqb_unused = slice_aeqb;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ALU_SEQ_AEQB_EN
    aeqb_d   = aeqb_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = cin;
          cnt_d   = 2'd0;
          state_d = RUN;
`ifdef ALU_SEQ_AEQB_EN
          aeqb_d  = 1'b1;
`endif
        end
      end
      RUN: begin
        result_d[4*cnt_q +: 4] = slice_f;
        carry_d = ~slice_cn4_n;
        cnt_d   = cnt_q + 2'd1;
`ifdef ALU_SEQ_AEQB_EN
        aeqb_d  = aeqb_q & slice_aeqb;
`endif
        if (cnt_q == 2'd3) begin
          cout_d  = m_q ? 1'b0 : ~slice_cn4_n;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

`ifdef ALU_SEQ_AEQB_EN
  always_ff @(posedge clk) begin
    if (rst) aeqb_q <= 1'b0;
    else     aeqb_q <= aeqb_d;
  end
  assign aeqb = aeqb_q & (state_q == DONE);
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  // Gated so that a freshly reset block reports zero=0 with its other outputs.
  assign zero      = out_valid && (result_q == 16'h0000);

endmodule
